// File: rtl/ecpdlycal_pkg.sv
// Shared types for the pin-delay calibration sequencer: FSM encoding and
// the status-bit layout exported to the control register file.
package ecpdlycal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_FINAL,
    ST_DONE,
    ST_FAIL
  } cal_state_e;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_FAIL_BIT = 2;
  localparam int STAT_W        = 3;

  typedef struct packed {
    logic fail;
    logic done;
    logic busy;
  } cal_status_t;

endpackage

// File: rtl/ecpdlycal_win.sv
// Passing-window tracker: follows the current run of passing taps and keeps
// the longest run seen so far (earliest run wins a tie).
module ecpdlywin #(
  parameter int NBITS = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             clear,
  input  logic             eval,
  input  logic             pass,
  input  logic             close,
  input  logic [NBITS-1:0] tap,
  output logic [NBITS-1:0] best_start,
  output logic [NBITS-1:0] best_len
);

  logic [NBITS-1:0] run_start;
  logic [NBITS-1:0] run_len;
  logic [NBITS-1:0] eff_start;
  logic [NBITS-1:0] eff_len;
  logic             do_close;

  // Run as it stands after this tap's verdict, so a run ending on the last
  // tap is closed in the same cycle it is extended.
  always_comb begin
    eff_start = run_start;
    eff_len   = run_len;
    if (eval && pass) begin
      eff_len = run_len + 1'b1;
      if (run_len == '0) eff_start = tap;
    end
    do_close = close || (eval && !pass);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || clear) begin
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (do_close) begin
      if (eff_len > best_len) begin
        best_start <= eff_start;
        best_len   <= eff_len;
      end
      run_len <= '0;
    end else if (eval) begin
      run_start <= eff_start;
      run_len   <= eff_len;
    end
  end

endmodule

// File: rtl/ecpdlycal.sv
// Delay calibration sequencer: sweeps taps, scores each with checker samples,
// commands the centre of the widest passing window; manual override in IDLE.
//  state  | meaning
//  IDLE   | manual override tracking, waiting for start
//  MOVE   | command tap, wait for controller match or timeout
//  SETTLE | let the new delay settle, samples ignored
//  SAMPLE | count samples and errors for the current tap
//  EVAL   | score tap, update windows, advance or finish
//  FINAL  | check window width, move to centre
//  DONE   | flag success
//  FAIL   | flag failure, command 0
module ecpdlycal
  import ecpdlycal_pkg::*;
#(
  parameter int NBITS      = 16,
  parameter int DMAX       = 127,
  parameter int NSAMPLE_LG = 10,
  parameter int ERR_THRESH = 0,
  parameter int MIN_WIN    = 4,
  parameter int SETTLE     = 16,
  parameter int MOVE_TO_LG = 12
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cal_start,
  input  logic             i_manual,
  input  logic [NBITS-1:0] i_manual_delay,
  input  logic [NBITS-1:0] i_current_delay,
  input  logic             i_sample_valid,
  input  logic             i_sample_ok,
  output logic [NBITS-1:0] o_commanded_delay,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_fail,
  output logic [NBITS-1:0] o_win_start,
  output logic [NBITS-1:0] o_win_len
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int CW = NSAMPLE_LG + 1;
  localparam logic [SW-1:0]         SETTLE_LOAD = SW'(SETTLE - 1);
  localparam logic [MOVE_TO_LG-1:0] MOVE_LOAD   = '1;
  localparam logic [CW-1:0]         SMP_LAST    = CW'((2 ** NSAMPLE_LG) - 1);
  localparam logic [NBITS-1:0]      TAP_LAST    = NBITS'(DMAX);

  cal_state_e             state, state_nx;
  cal_status_t            stat;
  logic [NBITS-1:0]       tap;
  logic [NBITS-1:0]       cmd;
  logic [MOVE_TO_LG-1:0]  move_cnt;
  logic [SW-1:0]          settle_cnt;
  logic [CW-1:0]          smp_cnt;
  logic [CW-1:0]          err_cnt;
  logic                   final_wait;
  logic                   win_clear, win_eval, win_close;
  logic                   tap_pass, delay_match, move_to;
  logic [NBITS-1:0]       best_start, best_len, centre;

  assign delay_match = (i_current_delay == cmd);
  assign move_to     = (move_cnt == '0);
  assign tap_pass    = ({{(32-CW){1'b0}}, err_cnt} <= 32'(ERR_THRESH));
  assign centre      = best_start + (best_len >> 1);

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    win_clear = 1'b0;
    win_eval  = 1'b0;
    win_close = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!i_manual && i_cal_start) begin
          state_nx  = ST_MOVE;
          win_clear = 1'b1;
        end
      end
      ST_MOVE: begin
        if (delay_match)  state_nx = ST_SETTLE;
        else if (move_to) state_nx = ST_FAIL;
      end
      ST_SETTLE: if (settle_cnt == '0) state_nx = ST_SAMPLE;
      ST_SAMPLE: if (i_sample_valid && smp_cnt == SMP_LAST) state_nx = ST_EVAL;
      ST_EVAL: begin
        win_eval = 1'b1;
        if (tap == TAP_LAST) begin
          win_close = 1'b1;
          state_nx  = ST_FINAL;
        end else begin
          state_nx = ST_MOVE;
        end
      end
      ST_FINAL: begin
        if (!final_wait) begin
          if (best_len < NBITS'(MIN_WIN)) state_nx = ST_FAIL;
        end else if (delay_match) begin
          state_nx = ST_DONE;
        end else if (move_to) begin
          state_nx = ST_FAIL;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      ST_FAIL: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stat       <= '0;
      tap        <= '0;
      cmd        <= '0;
      move_cnt   <= '0;
      settle_cnt <= '0;
      smp_cnt    <= '0;
      err_cnt    <= '0;
      final_wait <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_manual) begin
            cmd <= i_manual_delay;
          end else if (i_cal_start) begin
            stat       <= '{fail: 1'b0, done: 1'b0, busy: 1'b1};
            tap        <= '0;
            cmd        <= '0;
            move_cnt   <= MOVE_LOAD;
            final_wait <= 1'b0;
          end
        end
        ST_MOVE: begin
          if (!delay_match) move_cnt <= move_cnt - 1'b1;
          settle_cnt <= SETTLE_LOAD;
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt - 1'b1;
          smp_cnt    <= '0;
          err_cnt    <= '0;
        end
        ST_SAMPLE: begin
          if (i_sample_valid) begin
            smp_cnt <= smp_cnt + 1'b1;
            if (!i_sample_ok && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end
        end
        ST_EVAL: begin
          if (tap != TAP_LAST) begin
            tap      <= tap + 1'b1;
            cmd      <= tap + 1'b1;
            move_cnt <= MOVE_LOAD;
          end
        end
        ST_FINAL: begin
          if (!final_wait) begin
            if (best_len >= NBITS'(MIN_WIN)) begin
              cmd        <= centre;
              final_wait <= 1'b1;
              move_cnt   <= MOVE_LOAD;
            end
          end else if (!delay_match) begin
            move_cnt <= move_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          stat.done <= 1'b1;
          stat.busy <= 1'b0;
        end
        ST_FAIL: begin
          stat.fail <= 1'b1;
          stat.busy <= 1'b0;
          cmd       <= '0;
        end
        default: ;
      endcase
    end
  end

  ecpdlywin #(.NBITS(NBITS)) u_win (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .clear      (win_clear),
    .eval       (win_eval),
    .pass       (tap_pass),
    .close      (win_close),
    .tap        (tap),
    .best_start (best_start),
    .best_len   (best_len)
  );

  assign o_commanded_delay = cmd;
  assign o_busy            = stat.busy;
  assign o_done            = stat.done;
  assign o_fail            = stat.fail;
  assign o_win_start       = best_start;
  assign o_win_len         = best_len;

endmodule

// File: tb/tb_ecpdlycal.sv
// Directed bench for ecpdlycal: delay model follows the command one tap per
// 8 clocks, the checker verdict is a per-tap pass mask.
module tb_ecpdlycal;

  localparam int NBITS = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cal_start = 1'b0;
  logic             manual = 1'b0;
  logic [NBITS-1:0] manual_delay = '0;
  logic [NBITS-1:0] cur = '0;
  logic             sample_valid = 1'b1;
  logic             sample_ok;
  logic [NBITS-1:0] cmd;
  logic             busy, done, fail;
  logic [NBITS-1:0] win_start, win_len;

  logic [31:0] mask = '0;
  logic        freeze = 1'b0;
  logic [2:0]  step = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign sample_ok = mask[cur[4:0]];

  always @(posedge clk) begin
    if (!freeze) begin
      step <= step + 3'd1;
      if (step == 3'd7) begin
        if (cur < cmd)      cur <= cur + 16'd1;
        else if (cur > cmd) cur <= cur - 16'd1;
      end
    end
  end

  ecpdlycal #(
    .NBITS(NBITS), .DMAX(31), .NSAMPLE_LG(4), .ERR_THRESH(0),
    .MIN_WIN(4), .SETTLE(4), .MOVE_TO_LG(12)
  ) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_cal_start       (cal_start),
    .i_manual          (manual),
    .i_manual_delay    (manual_delay),
    .i_current_delay   (cur),
    .i_sample_valid    (sample_valid),
    .i_sample_ok       (sample_ok),
    .o_commanded_delay (cmd),
    .o_busy            (busy),
    .o_done            (done),
    .o_fail            (fail),
    .o_win_start       (win_start),
    .o_win_len         (win_len)
  );

  task automatic run_cal(input logic [31:0] m, input string name);
    bit finished;
    mask = m;
    @(negedge clk) cal_start = 1'b1;
    @(negedge clk) cal_start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start got %0b want 1", name, busy);
    end
    finished = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s sweep_timeout busy still 1 after 20000 cycles", name);
    end
  endtask

  task automatic expect_result(input string name, input logic d, input logic f,
                               input int ws, input int wl, input int c);
    checks++;
    if (done !== d) begin errors++; $display("FAIL %s done got %0b want %0b", name, done, d); end
    checks++;
    if (fail !== f) begin errors++; $display("FAIL %s fail got %0b want %0b", name, fail, f); end
    checks++;
    if (win_start !== NBITS'(ws)) begin errors++; $display("FAIL %s win_start got %0d want %0d", name, win_start, ws); end
    checks++;
    if (win_len !== NBITS'(wl)) begin errors++; $display("FAIL %s win_len got %0d want %0d", name, win_len, wl); end
    checks++;
    if (cmd !== NBITS'(c)) begin errors++; $display("FAIL %s cmd got %0d want %0d", name, cmd, c); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_result("reset", 1'b0, 1'b0, 0, 0, 0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %0b want 0", busy); end
  endtask

  task automatic test_centre_window();
    run_cal(32'h000F_FC00, "centre");
    expect_result("centre", 1'b1, 1'b0, 10, 10, 15);
    checks++;
    if (cur !== 16'd15) begin errors++; $display("FAIL centre cur_delay got %0d want 15", cur); end
  endtask

  task automatic test_tie();
    run_cal(32'h00F0_003C, "tie");
    expect_result("tie", 1'b1, 1'b0, 2, 4, 4);
  endtask

  task automatic test_edge_window();
    run_cal(32'hF000_0000, "edge");
    expect_result("edge", 1'b1, 1'b0, 28, 4, 30);
  endtask

  task automatic test_narrow();
    run_cal(32'h0000_00E0, "narrow");
    expect_result("narrow", 1'b0, 1'b1, 5, 3, 0);
  endtask

  task automatic test_timeout();
    bit at_zero;
    at_zero = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cur == '0) begin at_zero = 1'b1; break; end
    end
    checks++;
    if (!at_zero) begin errors++; $display("FAIL timeout model_return cur got %0d want 0", cur); end
    freeze = 1'b1;
    run_cal(32'h000F_FC00, "timeout");
    expect_result("timeout", 1'b0, 1'b1, 0, 0, 0);
    freeze = 1'b0;
  endtask

  task automatic test_reset_mid_sample();
    bit reached;
    mask = 32'h000F_FC00;
    @(negedge clk) cal_start = 1'b1;
    @(negedge clk) cal_start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd == 16'd3 && cur == 16'd3) begin reached = 1'b1; break; end
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL midreset reach_tap3 cmd %0d cur %0d want 3", cmd, cur); end
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    checks++;
    if (cmd !== '0) begin errors++; $display("FAIL midreset cmd got %0d want 0", cmd); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset busy got %0b want 0", busy); end
    run_cal(32'h000F_FC00, "restart");
    expect_result("restart", 1'b1, 1'b0, 10, 10, 15);
  endtask

  task automatic test_manual();
    @(negedge clk);
    manual = 1'b1;
    manual_delay = 16'd9;
    #1;
    checks++;
    if (cmd !== 16'd15) begin errors++; $display("FAIL manual pre_edge cmd got %0d want 15", cmd); end
    @(posedge clk); #1;
    checks++;
    if (cmd !== 16'd9) begin errors++; $display("FAIL manual latency cmd got %0d want 9", cmd); end
    @(negedge clk) cal_start = 1'b1;
    @(negedge clk) cal_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL manual busy got %0b want 0", busy); end
    checks++;
    if (cmd !== 16'd9) begin errors++; $display("FAIL manual hold cmd got %0d want 9", cmd); end
    manual = 1'b0;
  endtask

  initial begin
    test_reset();
    test_centre_window();
    test_tie();
    test_edge_window();
    test_narrow();
    test_timeout();
    test_reset_mid_sample();
    test_manual();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
